// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding request to instruction memory, a
// single-entry instruction register, branch redirect and misaligned-target trap.
//
// state | meaning
// IDLE  | first cycle after reset release
// FETCH | imem_req driven with imem_addr = pc
// WAIT  | waiting for the response to the current request
// HOLD  | instr register valid, waiting for downstream to consume it
// DRAIN | redirected while a response is in flight; drop that response
// FAULT | misaligned redirect seen; dead until reset
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4,
    FAULT = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] pc;

  assign imem_addr = pc;
  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
      fetch_fault <= 1'b0;
    end else begin
      imem_req <= 1'b0;
      if (redirect_valid && state != FAULT) begin
        instr_valid <= 1'b0;
        if (redirect_pc[1:0] != 2'b00) begin
          fetch_fault <= 1'b1;
          state       <= FAULT;
        end else begin
          pc <= redirect_pc;
          // A request still in flight must be swallowed before refetching.
          if ((state == WAIT && !imem_rvalid) || state == DRAIN) begin
            state <= DRAIN;
          end else begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
      end else begin
        case (state)
          IDLE: begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
          FETCH: state <= WAIT;
          WAIT: begin
            if (imem_rvalid) begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              pc          <= pc + 32'd4;
              instr_valid <= 1'b1;
              state       <= HOLD;
            end
          end
          HOLD: begin
            if (!stall) begin
              instr_valid <= 1'b0;
              state       <= FETCH;
              imem_req    <= 1'b1;
            end
          end
          DRAIN: begin
            if (imem_rvalid) begin
              state    <= FETCH;
              imem_req <= 1'b1;
            end
          end
          FAULT: state <= FAULT;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a second instance with RESET_PC at the
// top of the address space shares all inputs to exercise pc wraparound.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;

  logic        imem_req, instr_valid, fetch_fault;
  logic [31:0] imem_addr, instr, instr_pc;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;

  logic        w_imem_req, w_instr_valid, w_fetch_fault;
  logic [31:0] w_imem_addr, w_instr, w_instr_pc;
  logic [6:0]  w_opcode, w_funct7;
  logic [2:0]  w_funct3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .fetch_fault(fetch_fault)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .instr_valid(w_instr_valid), .instr(w_instr), .instr_pc(w_instr_pc),
    .opcode(w_opcode), .funct3(w_funct3), .funct7(w_funct7),
    .fetch_fault(w_fetch_fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    tick(); tick();
    chk("rst_req",   {31'h0, imem_req},    32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr,                32'h0);
    chk("rst_ipc",   instr_pc,             32'h0);
    chk("rst_fault", {31'h0, fetch_fault}, 32'h0);
    chk("rst_addr",  imem_addr,            32'h0);
    chk("rst_addr_w", w_imem_addr,         32'hFFFF_FFFC);

    // basic fetch: request cycle 1, response cycle 2, instr_valid cycle 3
    rst_n = 1'b1;
    tick();
    chk("c1_req",    {31'h0, imem_req}, 32'h1);
    chk("c1_addr",   imem_addr,         32'h0);
    chk("c1_addr_w", w_imem_addr,       32'hFFFF_FFFC);
    tick();
    chk("c2_req", {31'h0, imem_req}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0020_81B3;
    tick();
    imem_rvalid = 1'b0;
    chk("c3_valid",  {31'h0, instr_valid}, 32'h1);
    chk("c3_instr",  instr,                32'h0020_81B3);
    chk("c3_ipc",    instr_pc,             32'h0);
    chk("c3_opcode", {25'h0, opcode},      32'h33);
    chk("c3_funct3", {29'h0, funct3},      32'h0);
    chk("c3_funct7", {25'h0, funct7},      32'h0);
    chk("c3_ipc_w",  w_instr_pc,           32'hFFFF_FFFC);
    tick();
    chk("c4_req",    {31'h0, imem_req},    32'h1);
    chk("c4_addr",   imem_addr,            32'h4);
    chk("c4_valid",  {31'h0, instr_valid}, 32'h0);
    chk("wrap_addr", w_imem_addr,          32'h0);

    // stall holds the instruction; rvalid during HOLD is ignored
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h40B5_0533; stall = 1'b1;
    tick();
    imem_rvalid = 1'b0;
    chk("st_funct7", {25'h0, funct7}, 32'h20);
    for (int i = 0; i < 5; i++) begin
      imem_rvalid = (i == 2); imem_rdata = 32'hDEAD_BEEF;
      tick();
      chk("st_req",   {31'h0, imem_req},    32'h0);
      chk("st_valid", {31'h0, instr_valid}, 32'h1);
      chk("st_instr", instr,                32'h40B5_0533);
      chk("st_ipc",   instr_pc,             32'h4);
    end
    imem_rvalid = 1'b0; stall = 1'b0;
    tick();
    chk("st_rel_req",   {31'h0, imem_req}, 32'h1);
    chk("st_rel_addr",  imem_addr,         32'h8);
    chk("st_rel_valid", {31'h0, instr_valid}, 32'h0);

    // redirect while waiting, stale response two cycles later
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    chk("dr_req", {31'h0, imem_req}, 32'h0);
    tick();
    chk("dr_req2", {31'h0, imem_req}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'hBADB_AD00;
    tick();
    imem_rvalid = 1'b0;
    chk("dr_req3",  {31'h0, imem_req},    32'h1);
    chk("dr_addr",  imem_addr,            32'h100);
    chk("dr_valid", {31'h0, instr_valid}, 32'h0);
    chk("dr_instr", instr,                32'h40B5_0533);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    tick();
    imem_rvalid = 1'b0;
    chk("dr_new_instr", instr,    32'h0000_0013);
    chk("dr_new_ipc",   instr_pc, 32'h100);
    tick();
    chk("dr_next_addr", imem_addr, 32'h104);

    // redirect and response in the same WAIT cycle
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    imem_rvalid = 1'b0; redirect_valid = 1'b0;
    chk("sc_req",   {31'h0, imem_req},    32'h1);
    chk("sc_addr",  imem_addr,            32'h200);
    chk("sc_valid", {31'h0, instr_valid}, 32'h0);
    chk("sc_instr", instr,                32'h0000_0013);

    // redirect during FETCH refetches immediately
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    chk("rf_req",  {31'h0, imem_req}, 32'h1);
    chk("rf_addr", imem_addr,         32'h300);

    // misaligned redirect traps until reset
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    tick();
    chk("ft_fault", {31'h0, fetch_fault}, 32'h1);
    chk("ft_valid", {31'h0, instr_valid}, 32'h0);
    chk("ft_req",   {31'h0, imem_req},    32'h0);
    redirect_pc = 32'h0000_0400; imem_rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ft_hold_req",   {31'h0, imem_req},    32'h0);
      chk("ft_hold_fault", {31'h0, fetch_fault}, 32'h1);
    end
    redirect_valid = 1'b0; imem_rvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ft_rst_fault", {31'h0, fetch_fault}, 32'h0);
    chk("ft_rst_addr",  imem_addr,            32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ft_post_req",  {31'h0, imem_req}, 32'h1);
    chk("ft_post_addr", imem_addr,         32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
